sync_fifo: RTL
==============

# sync_fifo

Single-clock, parametrised FIFO for buffering within one clock domain. It is the successor to the team's dual-clock pointer FIFO. Depth and width are configurable. It adds a selectable first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow and underflow error flags. A push and a pop in the same cycle are both accepted when the FIFO is full.

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 5: address width; depth = 2**ADDR_WIDTH.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_THRESH, 2**ADDR_WIDTH-4: almost_full asserts when count >= this value.
- AEMPTY_THRESH, 4: almost_empty asserts when count <= this value.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  write data.
- enqueue  in  1  push request.
- dequeue  in  1  pop request.
- clear_errors  in  1  clears overflow and underflow.
- data_out  out  DATA_WIDTH  read data.
- valid_out  out  1  data_out is valid (see Operation).
- full, empty  out  1  occupancy flags.
- almost_full, almost_empty  out  1  threshold flags.
- count  out  ADDR_WIDTH+1  words stored, range 0..2**ADDR_WIDTH.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide.
  - The low ADDR_WIDTH bits address memory; the pointers wrap naturally.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits are equal.
- rd_acc = dequeue && !empty. There is no bypass: a pop against an empty FIFO is rejected even if enqueue is high in the same cycle.
- wr_acc = enqueue && (!full || rd_acc). When full, a simultaneous accepted pop frees the slot for the push.
- count:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - Must always equal wr_ptr - rd_ptr.
- almost_full and almost_empty are combinational compares on registered count.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] and valid_out = 1 for the next cycle only.
  - Otherwise valid_out = 0 and data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally.
  - valid_out = !empty.
  - dequeue consumes the word currently shown.
- overflow sets when enqueue && !wr_acc. underflow sets when dequeue && !rd_acc.
- Both error flags clear on clear_errors. If set and clear occur in the same cycle, set wins.
- Rejected operations never alter pointers, count or memory.

## Timing
- Reset (async assert, sync-safe release) clears:
  - pointers and count to 0;
  - data_out to 0, valid_out to 0;
  - full = 0, empty = 1;
  - almost_empty = 1, almost_full = (AFULL_THRESH == 0);
  - overflow and underflow to 0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored data immediately; the first post-reset write lands at address 0.
- Write at edge N: count and flags update at edge N.
  - FWFT: the word is visible on data_out after edge N.
  - Standard: the earliest pop is sampled at edge N+1, with data_out valid after edge N+1.
- Read latency in standard mode is 1 cycle from an accepted dequeue to valid_out.
- Flags are updated at the same edge as count. There is no extra pipeline delay.

## Structure
- Shared package or header holds:
  - the mode constants SYNC_FIFO_STD = 0 and SYNC_FIFO_FWFT = 1;
  - the count/pointer width derivation (ADDR_WIDTH+1).
- The natural sub-module is fifo_ram: 2**ADDR_WIDTH x DATA_WIDTH, one synchronous write port and one asynchronous read port. The FWFT and standard paths both read from it.
- The top level holds the pointers, count, flags and read-mode muxing.

## Test plan
Bench configuration: DATA_WIDTH=8, ADDR_WIDTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1, run in both modes.
- Fill and drain:
  - Push 0x11, 0x22, 0x33, 0x44: full=1, count=4, almost_full=1.
  - A 5th push of 0x55 is rejected and sets overflow. Pops return 11, 22, 33, 44 in order, then empty=1.
- Full plus simultaneous push and pop:
  - With 4 words stored, enqueue 0x99 and dequeue together: pop returns 0x11, count stays 4.
  - Draining then yields 22, 33, 44, 99.
- Empty plus simultaneous push and pop:
  - With count=0, enqueue 0xAA and dequeue together: pop rejected, underflow=1, count=1.
  - A later pop returns 0xAA.
- Wrap-around: push and pop 10 words (0x01 to 0x0A) keeping count <= 2. Output order is preserved and count never exceeds 2.
- Sticky flags: with overflow=1, clear_errors=1 in the same cycle as a rejected push leaves overflow=1. clear_errors=1 alone clears it to 0.
- Reset mid-stream: with 3 words stored, pulse rst_n low between edges. Count=0, empty=1 and valid_out=0 take effect immediately; the next push/pop returns the new data only.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants for the single-clock FIFO: read-mode selectors and
// the pointer/count width derivation used by the top level.
package sync_fifo_pkg;

  localparam int unsigned SYNC_FIFO_STD  = 0;
  localparam int unsigned SYNC_FIFO_FWFT = 1;

  // One extra bit beyond the address distinguishes full from empty.
  function automatic int unsigned sync_fifo_ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo: synchronous write port, asynchronous read port.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with selectable registered or first-word-fall-through
// read, occupancy count, threshold flags and sticky error flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned FWFT          = SYNC_FIFO_STD,
  parameter int unsigned AFULL_THRESH  = 2 ** ADDR_WIDTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  enqueue,
  input  logic                  dequeue,
  input  logic                  clear_errors,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned    PW       = sync_fifo_ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0]  AFULL_T  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0]  AEMPTY_T = PW'(AEMPTY_THRESH);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

  // A pop never bypasses an empty FIFO; a pop frees the slot for a push when full.
  assign rd_acc = dequeue && !empty;
  assign wr_acc = enqueue && (!full || rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    if (clear_errors) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (enqueue && !wr_acc) overflow_d  = 1'b1;
    if (dequeue && !rd_acc) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_acc),
    .waddr_i(wr_ptr_q[PW-2:0]),
    .wdata_i(data_in),
    .raddr_i(rd_ptr_q[PW-2:0]),
    .rdata_o(rd_data)
  );

  assign count        = count_q;
  assign almost_full  = (count_q >= AFULL_T);
  assign almost_empty = (count_q <= AEMPTY_T);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  generate
    if (FWFT == SYNC_FIFO_FWFT) begin : g_fwft
      // Memory is not reset, so the shown word is masked while empty.
      assign data_out  = empty ? '0 : rd_data;
      assign valid_out = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  valid_q, valid_d;

      always_comb begin
        data_d  = data_q;
        valid_d = rd_acc;
        if (rd_acc) data_d = rd_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          data_q  <= data_d;
          valid_q <= valid_d;
        end
      end

      assign data_out  = data_q;
      assign valid_out = valid_q;
    end
  endgenerate

endmodule
